// File: rtl/cpu_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_axi_pkg
// Brief  : Shared constants for the CPU-side AXI bridges. Covers the AXI burst,
//          cache, prot and lock defaults, the sram-like size encodings and the
//          AXI response codes.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
    localparam logic [7:0] AXI_ARLEN_SINGLE    = 8'd0;
    localparam logic [3:0] AXI_ARCACHE_DEFAULT = 4'b0000;
    localparam logic [2:0] AXI_ARPROT_DEFAULT  = 3'b000;
    localparam logic [1:0] AXI_ARLOCK_DEFAULT  = 2'b00;
    localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;

    // sram-like transfer size encodings
    typedef enum logic [1:0] {
        SRAM_SIZE_BYTE = 2'd0,
        SRAM_SIZE_HALF = 2'd1,
        SRAM_SIZE_WORD = 2'd2
    } sram_size_e;

    // The sram-like size is already log2(bytes), which is exactly AXI AxSIZE.
    function automatic logic [2:0] sram_to_axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_ar_slot.sv
`default_nettype none
// ============================================================================
// Module : inst_ar_slot
// Brief  : One-entry AR holding register. A request loaded here is presented
//          on AR until the slave takes it. The slot may be reloaded in the
//          same cycle as the handshake, which gives back-to-back ARs.
// Ports  : clk, resetn  - clock, async active-low reset
//          load         - capture ld_addr/ld_size (request accepted)
//          ld_addr/size - request being accepted
//          arready      - AR handshake from the slave
//          busy         - slot holds a request (drives arvalid)
//          free         - slot can take a request this cycle
//          addr/size    - held request (drives araddr/arsize)
// Rev    : 1.0  initial release
// ============================================================================
module inst_ar_slot (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    input  logic        arready,
    output logic        busy,
    output logic        free,
    output logic [31:0] addr,
    output logic [1:0]  size
);

    logic        busy_q, busy_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;

    always_comb begin
        busy_d = busy_q;
        addr_d = addr_q;
        size_d = size_q;
        if (busy_q && arready) begin
            busy_d = 1'b0;
        end
        // A load wins over the handshake release, so the slot refills in place.
        if (load) begin
            busy_d = 1'b1;
            addr_d = ld_addr;
            size_d = ld_size;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            addr_q <= '0;
            size_q <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
            size_q <= size_d;
        end
    end

    assign busy = busy_q;
    assign free = ~busy_q | arready;
    assign addr = addr_q;
    assign size = size_q;

endmodule
`default_nettype wire

// File: rtl/inst_axi_rbridge.sv
`default_nettype none
// ============================================================================
// Module : inst_axi_rbridge
// Brief  : Instruction-side sram-like to AXI4 read bridge. Each accepted
//          sram-like read becomes one single-beat AXI read. Up to
//          MAX_OUTSTANDING reads may be in flight, and they return in order.
// Ports  : inst_sram_*  - sram-like request/response port toward IF
//          ar*          - AXI read address channel
//          r*           - AXI read data channel (rid ignored, single ID)
//          inst_bus_err - error pulse alongside data_ok on a non-OKAY rresp
// Config : `define INST_AXI_RRESP_CHECK_EN enables inst_bus_err. When it is
//          not defined, inst_bus_err is tied low and rresp is ignored.
// Rev    : 1.0  initial release
// ============================================================================
module inst_axi_rbridge
    import cpu_axi_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] ARID_VAL        = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        inst_bus_err
);

    localparam int             CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rready_q, rready_d;

    logic        w_slot_busy;
    logic        w_slot_free;
    logic [31:0] w_slot_addr;
    logic [1:0]  w_slot_size;
    logic        w_accept;
    logic        w_addr_ok;
    logic        w_data_ok;

    // Only the registered count gates acceptance: a slot freed by a same-cycle
    // data_ok is not reused until the next cycle, keeping addr_ok off the R path.
    assign w_accept  = w_slot_free & (cnt_q < CNT_MAX);
    assign w_addr_ok = inst_sram_req & w_accept & resetn;

    // A beat arriving with nothing outstanding is consumed but not reported.
    assign w_data_ok = rvalid & rready_q & rlast & (cnt_q != '0);

    inst_ar_slot u_ar_slot (
        .clk     (clk),
        .resetn  (resetn),
        .load    (w_addr_ok),
        .ld_addr (inst_sram_addr),
        .ld_size (inst_sram_size),
        .arready (arready),
        .busy    (w_slot_busy),
        .free    (w_slot_free),
        .addr    (w_slot_addr),
        .size    (w_slot_size)
    );

    always_comb begin
        cnt_d    = cnt_q;
        rready_d = 1'b1;
        case ({w_addr_ok, w_data_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            rready_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rready_q <= rready_d;
        end
    end

    assign inst_sram_addr_ok = w_addr_ok;
    assign inst_sram_data_ok = w_data_ok;
    assign inst_sram_rdata   = rdata;

    assign arid    = ARID_VAL;
    assign araddr  = w_slot_addr;
    assign arlen   = AXI_ARLEN_SINGLE;
    assign arsize  = sram_to_axi_size(w_slot_size);
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_ARLOCK_DEFAULT;
    assign arcache = AXI_ARCACHE_DEFAULT;
    assign arprot  = AXI_ARPROT_DEFAULT;
    assign arvalid = w_slot_busy;
    assign rready  = rready_q;

`ifdef INST_AXI_RRESP_CHECK_EN
    // data_ok is already low during reset, so the pulse needs no extra gating.
    assign inst_bus_err = w_data_ok & (rresp != AXI_RESP_OKAY);
    logic w_unused_inputs;
    assign w_unused_inputs = ^rid;
`else
    assign inst_bus_err = 1'b0;
    logic w_unused_inputs;
    assign w_unused_inputs = ^{rid, rresp};
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_axi_rbridge.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_axi_rbridge
// Brief  : Self-checking bench for inst_axi_rbridge. A queue-based model of
//          the bridge (AR slot queue, outstanding list, AXI responder queue)
//          predicts every output each cycle. Directed sequences pin the model
//          with literal values, followed by a randomized run.
// Rev    : 1.0  initial release
// ============================================================================
module tb_inst_axi_rbridge;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        inst_bus_err;

    always #5 clk = ~clk;

    inst_axi_rbridge #(.MAX_OUTSTANDING(MAX), .ARID_VAL(4'd3)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .inst_bus_err(inst_bus_err)
    );

    int errors = 0;
    int checks = 0;

    // model state
    logic [31:0] pend_addr[$];   // accepted, waiting for AR handshake
    logic [1:0]  pend_size[$];
    logic [31:0] acc_q[$];       // accepted, waiting for data_ok (in order)
    logic [31:0] hs_q[$];        // AR handshaken, responder owes a beat
    bit          rdy_m;          // rready expected high
    int          r_mode;         // 0 idle, 1 return owed beat, 2 spurious beat
    bit          real_beat;

    // observed values of the last step, for literal checks
    logic        obs_addr_ok, obs_data_ok, obs_arvalid, obs_bus_err;
    logic [31:0] obs_araddr, obs_rdata;
    logic [2:0]  obs_arsize;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h1c00_0000) return 32'h0280_0c0c;
        return a ^ 32'ha5a5_1234;
    endfunction

    task automatic drive_r();
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rdata     = 32'hdead_beef;
        rid       = 4'd3;
        real_beat = 1'b0;
        if (r_mode == 1 && hs_q.size() > 0) begin
            rvalid = 1'b1; rlast = 1'b1; rdata = mem_f(hs_q[0]); real_beat = 1'b1;
        end else if (r_mode == 2 && acc_q.size() == 0) begin
            rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0bad_0bad;
        end
    endtask

    // Inputs are set just after a posedge; checks happen at the negedge.
    task automatic step();
        bit e_arvalid, e_addr_ok, e_data_ok, e_err, slot_free;
        drive_r();
        @(negedge clk);
        e_arvalid = pend_addr.size() > 0;
        slot_free = (pend_addr.size() == 0) || arready;
        e_addr_ok = inst_sram_req && slot_free && (acc_q.size() < MAX);
        e_data_ok = rvalid && rlast && rdy_m && (acc_q.size() > 0);
`ifdef INST_AXI_RRESP_CHECK_EN
        e_err = e_data_ok && (rresp != 2'b00);
`else
        e_err = 1'b0;
`endif
        chk("arvalid", arvalid, e_arvalid);
        if (e_arvalid) begin
            chk("araddr", araddr, pend_addr[0]);
            chk("arsize", arsize, {1'b0, pend_size[0]});
        end
        chk("ar_const", {arid, arlen, arburst, arlock, arcache, arprot},
            {4'd3, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        chk("addr_ok", inst_sram_addr_ok, e_addr_ok);
        chk("data_ok", inst_sram_data_ok, e_data_ok);
        chk("rready", rready, rdy_m);
        chk("bus_err", inst_bus_err, e_err);
        if (e_data_ok) chk("rdata", inst_sram_rdata, mem_f(acc_q[0]));
        obs_addr_ok = inst_sram_addr_ok; obs_data_ok = inst_sram_data_ok;
        obs_arvalid = arvalid; obs_araddr = araddr; obs_arsize = arsize;
        obs_rdata = inst_sram_rdata; obs_bus_err = inst_bus_err;
        @(posedge clk);
        if (e_arvalid && arready) begin
            hs_q.push_back(pend_addr.pop_front());
            void'(pend_size.pop_front());
        end
        if (e_addr_ok) begin
            pend_addr.push_back(inst_sram_addr);
            pend_size.push_back(inst_sram_size);
            acc_q.push_back(inst_sram_addr);
        end
        if (e_data_ok) void'(acc_q.pop_front());
        if (real_beat && rdy_m) void'(hs_q.pop_front());
        rdy_m = 1'b1;
        #1;
    endtask

    task automatic drain();
        inst_sram_req = 1'b0; arready = 1'b1; r_mode = 1; rresp = 2'b00;
        for (int i = 0; i < 30 && acc_q.size() > 0; i++) step();
        chk("drain_timeout", acc_q.size(), 0);
        r_mode = 0;
    endtask

    task automatic model_reset();
        pend_addr.delete(); pend_size.delete(); acc_q.delete(); hs_q.delete();
        rdy_m = 1'b0;
    endtask

    initial begin
        // ---------------- reset values ----------------
        resetn = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000;
        inst_sram_size = 2'd2; arready = 1'b1; rresp = 2'b00;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678; rid = 4'd0;
        r_mode = 0; model_reset();
        #2;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_rready", rready, 0);
        chk("rst_addr_ok", inst_sram_addr_ok, 0);
        chk("rst_data_ok", inst_sram_data_ok, 0);
        chk("rst_bus_err", inst_bus_err, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_arvalid", arvalid, 0);
        resetn = 1'b1; inst_sram_req = 1'b0;

        // ---------------- single fetch ----------------
        step();                          // rready rises on this edge
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2;
        step();
        chk("t1_addr_ok", obs_addr_ok, 1);
        inst_sram_req = 1'b0;
        step();
        chk("t1_arvalid", obs_arvalid, 1);
        chk("t1_araddr", obs_araddr, 32'h1c00_0000);
        chk("t1_arsize", obs_arsize, 3'b010);
        step(); step();
        r_mode = 1;
        step();
        chk("t1_data_ok", obs_data_ok, 1);
        chk("t1_rdata", obs_rdata, 32'h0280_0c0c);
        r_mode = 0;

        // ---------------- AR backpressure ----------------
        arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0010;
        step();
        chk("bp_first_ok", obs_addr_ok, 1);
        inst_sram_addr = 32'h1c00_0014;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_blocked", obs_addr_ok, 0);
            chk("bp_hold_addr", obs_araddr, 32'h1c00_0010);
        end
        arready = 1'b1;
        step();
        chk("bp_hs_accept", obs_addr_ok, 1);
        drain();

        // ---------------- outstanding limit / simultaneous ----------------
        arready = 1'b1; r_mode = 0; inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1c00_0000; step(); chk("lim_ok0", obs_addr_ok, 1);
        inst_sram_addr = 32'h1c00_0004; step(); chk("lim_ok1", obs_addr_ok, 1);
        inst_sram_addr = 32'h1c00_0008; step(); chk("lim_blk0", obs_addr_ok, 0);
        step(); chk("lim_blk1", obs_addr_ok, 0);
        r_mode = 1; step();
        chk("lim_ret_data", obs_data_ok, 1);
        chk("lim_ret_rdata", obs_rdata, 32'h0280_0c0c);
        chk("lim_same_cycle_blk", obs_addr_ok, 0);
        r_mode = 0; step(); chk("lim_third_ok", obs_addr_ok, 1);
        inst_sram_req = 1'b0; r_mode = 1; step();
        chk("lim_order1", obs_rdata, 32'h1c00_0004 ^ 32'ha5a5_1234);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_000c; step();
        chk("sim_addr_ok", obs_addr_ok, 1);
        chk("sim_data_ok", obs_data_ok, 1);
        chk("sim_rdata", obs_rdata, 32'hb9a5_123c);
        r_mode = 0; inst_sram_addr = 32'h1c00_0010; step();
        chk("sim_cnt1_ok", obs_addr_ok, 1);
        inst_sram_addr = 32'h1c00_0014; step();
        chk("sim_cnt2_blk", obs_addr_ok, 0);
        drain();

        // ---------------- spurious beat / bus error ----------------
        r_mode = 2; inst_sram_req = 1'b0; step();
        chk("spur_no_data", obs_data_ok, 0);
        r_mode = 0; inst_sram_req = 1'b1; arready = 1'b1;
        inst_sram_addr = 32'h1c00_0020; step(); chk("spur_cnt_ok0", obs_addr_ok, 1);
        inst_sram_addr = 32'h1c00_0024; step(); chk("spur_cnt_ok1", obs_addr_ok, 1);
        inst_sram_req = 1'b0; step();
        r_mode = 1; rresp = 2'b10; step();
        chk("err_data_ok", obs_data_ok, 1);
`ifdef INST_AXI_RRESP_CHECK_EN
        chk("err_pulse", obs_bus_err, 1);
`else
        chk("err_tied", obs_bus_err, 0);
`endif
        rresp = 2'b00; step();
        chk("err_clear", obs_bus_err, 0);
        drain();

        // ---------------- async reset mid-transaction ----------------
        arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0040;
        step();
        chk("ar_pre_arvalid", arvalid, 1);
        #2 resetn = 1'b0;
        rvalid = 1'b1; rlast = 1'b1;
        #1;
        chk("ar_arvalid", arvalid, 0);
        chk("ar_rready", rready, 0);
        chk("ar_addr_ok", inst_sram_addr_ok, 0);
        chk("ar_data_ok", inst_sram_data_ok, 0);
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1; inst_sram_req = 1'b0; arready = 1'b1;
        step();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0050; step();
        chk("post_rst_ok0", obs_addr_ok, 1);
        inst_sram_addr = 32'h1c00_0054; step();
        chk("post_rst_ok1", obs_addr_ok, 1);
        drain();

        // ---------------- randomized run ----------------
        for (int n = 0; n < 2000; n++) begin
            int rr;
            inst_sram_req  = ($urandom_range(0, 99) < 60);
            inst_sram_addr = {$urandom(), 2'b00} & 32'hffff_fffc;
            inst_sram_size = 2'($urandom_range(0, 2));
            arready        = ($urandom_range(0, 1) == 1);
            rr = $urandom_range(0, 99);
            r_mode = (rr < 40) ? 1 : (rr < 46) ? 2 : 0;
            rresp  = ($urandom_range(0, 99) < 80) ? 2'b00 : 2'($urandom_range(1, 3));
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
